uart_rx: RTL and testbench

- Receive half of the UART transport layer; consumes the serial line driven by the transmit half (or the external peer).
- Deserializes 5–8 data bits LSB-first, with optional even/odd parity and 1 or 2 stop bits, using 16x oversampling.
- Frame configuration inputs match the transmit side.
- Presents the received byte with a valid/read handshake toward the register block, plus parity, framing and overrun status and RTS flow control.

---
 rtl/uart_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampled UART receiver, 5-8 data bits, optional parity,
//            1/2 stop bits, valid/read handshake, error flags and RTS.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int BAUD_RATE     = 115200,
    parameter int FREQUENCY_CLK = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_done,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overrun_error,
    output logic       rts_n,
    output logic       rx_busy
);

    localparam int OSR_DIV = FREQUENCY_CLK / (BAUD_RATE * 16);
    localparam int DIV_W   = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(OSR_DIV - 1);

    if (OSR_DIV < 1) begin : g_osr_check
        $error("uart_rx: FREQUENCY_CLK too low for 16x oversampling at BAUD_RATE");
    end

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_PARITY     = 3'd3,
        S_STOP1      = 3'd4,
        S_STOP2      = 3'd5,
        S_BREAK_WAIT = 3'd6
    } state_t;

    state_t           r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_s_d;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_smp_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [2:0]       r_cfg_last;
    logic             r_cfg_stop2;
    logic             r_cfg_par_en;
    logic             r_cfg_par_even;
    logic             r_par_flag;
    logic             r_frame_flag;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_done;
    logic             r_par_err;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_busy;

    logic w_tick;
    logic w_start_edge;
    logic w_mid_start;
    logic w_sample;
    logic w_par_exp;
    logic w_complete;

    assign w_tick       = (r_div_cnt == DIV_MAX);
    assign w_start_edge = (r_state == S_IDLE) && r_rx_s_d && !r_rx_s;
    assign w_mid_start  = w_tick && (r_smp_cnt == 4'd7);
    assign w_sample     = w_tick && (r_smp_cnt == 4'd15);
    // Bits above the configured width stay zero, so they do not disturb the XOR.
    assign w_par_exp    = (^r_shift) ^ ~r_cfg_par_even;
    assign w_complete   = w_sample &&
                          (((r_state == S_STOP1) && !r_cfg_stop2) || (r_state == S_STOP2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
        end
    end

    // Divider and sample counter restart on the start edge so mid-bit sampling
    // lines up with the falling edge; the counter restarts again at mid-start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_smp_cnt <= 4'd0;
        end else if (w_start_edge) begin
            r_div_cnt <= '0;
            r_smp_cnt <= 4'd0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_tick) begin
                if ((r_state == S_START) && (r_smp_cnt == 4'd7)) begin
                    r_smp_cnt <= 4'd0;
                end else begin
                    r_smp_cnt <= r_smp_cnt + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_bit_cnt      <= 3'd0;
            r_shift        <= 8'h00;
            r_cfg_last     <= 3'd0;
            r_cfg_stop2    <= 1'b0;
            r_cfg_par_en   <= 1'b0;
            r_cfg_par_even <= 1'b0;
            r_par_flag     <= 1'b0;
            r_frame_flag   <= 1'b0;
            r_data         <= 8'h00;
            r_valid        <= 1'b0;
            r_done         <= 1'b0;
            r_par_err      <= 1'b0;
            r_frame_err    <= 1'b0;
            r_overrun      <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (rx_read) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_mid_start) begin
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state        <= S_DATA;
                            r_bit_cnt      <= 3'd0;
                            r_shift        <= 8'h00;
                            r_cfg_last     <= {1'b0, data_bit_num} + 3'd4;
                            r_cfg_stop2    <= stop_bit_num;
                            r_cfg_par_en   <= parity_en;
                            r_cfg_par_even <= parity_type;
                            r_par_flag     <= 1'b0;
                            r_frame_flag   <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift[r_bit_cnt] <= r_rx_s;
                        if (r_bit_cnt == r_cfg_last) begin
                            r_state <= r_cfg_par_en ? S_PARITY : S_STOP1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_sample) begin
                        r_par_flag <= (r_rx_s != w_par_exp);
                        r_state    <= S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (w_sample && r_cfg_stop2) begin
                        r_frame_flag <= ~r_rx_s;
                        r_state      <= S_STOP2;
                    end
                end
                S_STOP2: begin
                end
                S_BREAK_WAIT: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Completion overrides a coincident rx_read; overrun looks at the
            // valid flag as it stood before this cycle.
            if (w_complete) begin
                r_done      <= 1'b1;
                r_data      <= r_shift;
                r_par_err   <= r_par_flag;
                r_frame_err <= r_frame_flag | ~r_rx_s;
                r_valid     <= 1'b1;
                if (r_valid) begin
                    r_overrun <= 1'b1;
                end
                if (r_rx_s) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_state <= S_BREAK_WAIT;
                    r_busy  <= 1'b1;
                end
            end
        end
    end

    assign rx_data       = r_data;
    assign rx_data_valid = r_valid;
    assign rx_done       = r_done;
    assign parity_error  = r_par_err;
    assign frame_error   = r_frame_err;
    assign overrun_error = r_overrun;
    assign rts_n         = r_valid;
    assign rx_busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (OSR_DIV = 2, 32 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int BAUD     = 100000;
    localparam int FCLK     = 3200000;
    localparam int BIT_CLKS = 32;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_done;
    logic       parity_error;
    logic       frame_error;
    logic       overrun_error;
    logic       rts_n;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    uart_rx #(
        .BAUD_RATE    (BAUD),
        .FREQUENCY_CLK(FCLK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .data_bit_num (data_bit_num),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .rx_read      (rx_read),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .overrun_error(overrun_error),
        .rts_n        (rts_n),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done === 1'b1) done_cnt++;
    end

    task automatic drive_bits(input logic b, input int nbits);
        rx = b;
        repeat (nbits * BIT_CLKS) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] dbn, input logic sbn, input logic pen, input logic ptype);
        data_bit_num = dbn;
        stop_bit_num = sbn;
        parity_en    = pen;
        parity_type  = ptype;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                              input logic peven, input logic flip, input int nstop,
                              input logic stop_lvl);
        logic p;
        p = 1'b0;
        drive_bits(1'b0, 1);
        for (int i = 0; i < nbits; i++) begin
            drive_bits(d[i], 1);
            p = p ^ d[i];
        end
        if (pen) begin
            if (!peven) p = ~p;
            if (flip) p = ~p;
            drive_bits(p, 1);
        end
        for (int i = 0; i < nstop; i++) drive_bits(stop_lvl, 1);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({rx_data, rx_data_valid, rx_done, parity_error, frame_error, overrun_error, rts_n, rx_busy} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_in: outputs=%h expected 0000", {rx_data, rx_data_valid, rx_done, parity_error, frame_error, overrun_error, rts_n, rx_busy});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({rx_data, rx_data_valid, rx_done, parity_error, frame_error, overrun_error, rts_n, rx_busy} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_out: outputs=%h expected 0000", {rx_data, rx_data_valid, rx_done, parity_error, frame_error, overrun_error, rts_n, rx_busy});
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_start: got %b expected 1", rx_busy);
        end
        repeat (2) @(negedge clk);
        drive_bits(1'b1, 2);
        n_checks++;
        if (rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_idle: rx_busy=%b expected 0", rx_busy);
        end
        n_checks++;
        if (done_cnt !== 0 || {rx_data_valid, parity_error, frame_error, overrun_error} !== 4'b0) begin
            n_fail++;
            $display("FAIL glitch_flags: done_cnt=%0d flags=%b expected 0 and 0000", done_cnt, {rx_data_valid, parity_error, frame_error, overrun_error});
        end
    endtask

    task automatic test_8n1();
        int base;
        base = done_cnt;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        drive_bits(1'b1, 1);
        n_checks++;
        if (done_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL 8n1_done: pulses=%0d expected 1", done_cnt - base);
        end
        n_checks++;
        if (rx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL 8n1_data: got %h expected a5", rx_data);
        end
        n_checks++;
        if ({rx_data_valid, rts_n, rx_busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL 8n1_valid_rts_busy: got %b expected 110", {rx_data_valid, rts_n, rx_busy});
        end
        n_checks++;
        if ({parity_error, frame_error, overrun_error} !== 3'b000) begin
            n_fail++;
            $display("FAIL 8n1_errors: got %b expected 000", {parity_error, frame_error, overrun_error});
        end
        pulse_read();
        n_checks++;
        if ({rx_data_valid, rts_n} !== 2'b00) begin
            n_fail++;
            $display("FAIL 8n1_read: valid/rts_n=%b expected 00", {rx_data_valid, rts_n});
        end
    endtask

    task automatic test_parity();
        set_cfg(2'b00, 1'b1, 1'b1, 1'b1);
        // Upper bits of 0xF3 are not transmitted; the 5-bit payload is 0x13.
        send_frame(8'hF3, 5, 1'b1, 1'b1, 1'b0, 2, 1'b1);
        drive_bits(1'b1, 1);
        n_checks++;
        if ({rx_data, parity_error, frame_error} !== {8'h13, 2'b00}) begin
            n_fail++;
            $display("FAIL parity_good: data=%h perr=%b ferr=%b expected 13 0 0", rx_data, parity_error, frame_error);
        end
        pulse_read();
        send_frame(8'hF3, 5, 1'b1, 1'b1, 1'b1, 2, 1'b1);
        drive_bits(1'b1, 1);
        n_checks++;
        if ({rx_data, parity_error, frame_error} !== {8'h13, 2'b10}) begin
            n_fail++;
            $display("FAIL parity_bad: data=%h perr=%b ferr=%b expected 13 1 0", rx_data, parity_error, frame_error);
        end
        n_checks++;
        if (overrun_error !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_overrun: got %b expected 0", overrun_error);
        end
        pulse_read();
    endtask

    task automatic test_break();
        int base;
        base = done_cnt;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        drive_bits(1'b0, 2);
        n_checks++;
        if ({rx_data, frame_error, parity_error} !== {8'h5A, 2'b10}) begin
            n_fail++;
            $display("FAIL break_frame: data=%h ferr=%b perr=%b expected 5a 1 0", rx_data, frame_error, parity_error);
        end
        n_checks++;
        if (rx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL break_hold_busy: got %b expected 1", rx_busy);
        end
        drive_bits(1'b0, 1);
        drive_bits(1'b1, 2);
        n_checks++;
        if (rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_release: rx_busy=%b expected 0", rx_busy);
        end
        n_checks++;
        if (done_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL break_done: pulses=%0d expected 1", done_cnt - base);
        end
        pulse_read();
    endtask

    task automatic test_back_to_back();
        int base;
        base = done_cnt;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        n_checks++;
        if ({rx_data, rx_data_valid, overrun_error} !== {8'h11, 2'b10}) begin
            n_fail++;
            $display("FAIL b2b_first: data=%h valid=%b ovr=%b expected 11 1 0", rx_data, rx_data_valid, overrun_error);
        end
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        drive_bits(1'b1, 1);
        n_checks++;
        if ({rx_data, rx_data_valid, overrun_error} !== {8'h22, 2'b11}) begin
            n_fail++;
            $display("FAIL b2b_second: data=%h valid=%b ovr=%b expected 22 1 1", rx_data, rx_data_valid, overrun_error);
        end
        n_checks++;
        if (done_cnt - base !== 2) begin
            n_fail++;
            $display("FAIL b2b_done: pulses=%0d expected 2", done_cnt - base);
        end
        pulse_read();
        n_checks++;
        if ({rx_data_valid, rts_n, overrun_error} !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_read: valid/rts_n/ovr=%b expected 001", {rx_data_valid, rts_n, overrun_error});
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        drive_bits(1'b0, 1);
        drive_bits(1'b1, 1);
        drive_bits(1'b0, 1);
        drive_bits(1'b1, 1);
        n_checks++;
        if ({rx_busy, overrun_error} !== 2'b11) begin
            n_fail++;
            $display("FAIL midrst_pre: busy/ovr=%b expected 11", {rx_busy, overrun_error});
        end
        base = done_cnt;
        #1 reset = 1'b1;
        #2;
        n_checks++;
        if ({rx_data, rx_data_valid, rx_done, parity_error, frame_error, overrun_error, rts_n, rx_busy} !== 15'h0) begin
            n_fail++;
            $display("FAIL midrst_async: outputs=%h expected 0000", {rx_data, rx_data_valid, rx_done, parity_error, frame_error, overrun_error, rts_n, rx_busy});
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        drive_bits(1'b1, 6);
        n_checks++;
        if (done_cnt !== base || rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_done: pulses=%0d busy=%b expected 0 0", done_cnt - base, rx_busy);
        end
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        drive_bits(1'b1, 1);
        n_checks++;
        if ({rx_data, rx_data_valid, parity_error, frame_error, overrun_error} !== {8'h3C, 4'b1000}) begin
            n_fail++;
            $display("FAIL midrst_recover: data=%h v/p/f/o=%b expected 3c 1000", rx_data, {rx_data_valid, parity_error, frame_error, overrun_error});
        end
        n_checks++;
        if (done_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL midrst_done: pulses=%0d expected 1", done_cnt - base);
        end
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        rx_read = 1'b0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        test_reset();
        test_glitch();
        test_8n1();
        test_parity();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
